// File: rtl/byte_striping_tx.sv
// byte_striping_tx: splits one byte stream into even/odd lanes, flushing a lone even byte after FLUSH_CYCLES idle cycles.
// Optional parity outputs enabled by defining BYTE_STRIPING_TX_PARITY_EN.
module byte_striping_tx #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] lane_0,
    output logic       valid_0,
    output logic [7:0] lane_1,
    output logic       valid_1,
`ifdef BYTE_STRIPING_TX_PARITY_EN
    output logic       parity_0,
    output logic       parity_1,
`endif
    output logic       holding
);
    typedef enum logic {IDLE, HOLD} state_t;
    localparam logic [3:0] FLUSH = 4'(FLUSH_CYCLES);
    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d, lane_0_q, lane_0_d, lane_1_q, lane_1_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_0_q, valid_0_d, valid_1_q, valid_1_d;
    logic       flush;
    // The idle cycle that reaches FLUSH_CYCLES is the one that emits the lone byte.
    assign flush = (FLUSH != 4'd0) && (cnt_q + 4'd1 == FLUSH);
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        lane_0_d  = 8'h00;
        lane_1_d  = 8'h00;
        valid_0_d = 1'b0;
        valid_1_d = 1'b0;
        if (state_q == IDLE) begin
            if (valid_in) begin
                hold_d  = data_in;
                cnt_d   = 4'd0;
                state_d = HOLD;
            end
        end else if (valid_in) begin
            lane_0_d  = hold_q;
            lane_1_d  = data_in;
            valid_0_d = 1'b1;
            valid_1_d = 1'b1;
            cnt_d     = 4'd0;
            state_d   = IDLE;
        end else if (flush) begin
            lane_0_d  = hold_q;
            valid_0_d = 1'b1;
            cnt_d     = 4'd0;
            state_d   = IDLE;
        end else if (cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
    end
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= 8'h00;
            cnt_q     <= 4'd0;
            lane_0_q  <= 8'h00;
            lane_1_q  <= 8'h00;
            valid_0_q <= 1'b0;
            valid_1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            lane_0_q  <= lane_0_d;
            lane_1_q  <= lane_1_d;
            valid_0_q <= valid_0_d;
            valid_1_q <= valid_1_d;
        end
    end
`ifdef BYTE_STRIPING_TX_PARITY_EN
    logic parity_0_q, parity_1_q;
    // Lane data is zero when invalid, so parity is zero then too.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            parity_0_q <= 1'b0;
            parity_1_q <= 1'b0;
        end else begin
            parity_0_q <= ^lane_0_d;
            parity_1_q <= ^lane_1_d;
        end
    end
    assign parity_0 = parity_0_q;
    assign parity_1 = parity_1_q;
`endif
    assign lane_0  = lane_0_q;
    assign lane_1  = lane_1_q;
    assign valid_0 = valid_0_q;
    assign valid_1 = valid_1_q;
    assign holding = (state_q == HOLD);
endmodule

// File: tb/tb_byte_striping_tx.sv
// tb_byte_striping_tx: scoreboard bench for byte_striping_tx with directed vectors (FLUSH_CYCLES=2).
module tb_byte_striping_tx;
    logic       clk_2f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic [7:0] lane_0, lane_1;
    logic       valid_0, valid_1, holding;
    logic       p0, p1;
    int         tests = 0;
    int         fails = 0;
    logic [19:0] sb[$];

    byte_striping_tx #(.FLUSH_CYCLES(2)) dut (
        .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .lane_0(lane_0), .valid_0(valid_0), .lane_1(lane_1), .valid_1(valid_1),
`ifdef BYTE_STRIPING_TX_PARITY_EN
        .parity_0(p0), .parity_1(p1),
`endif
        .holding(holding)
    );
`ifndef BYTE_STRIPING_TX_PARITY_EN
    assign p0 = 1'b0;
    assign p1 = 1'b0;
`endif

    always #5 clk_2f = ~clk_2f;

    function automatic logic [19:0] ev(logic v0, logic [7:0] l0, logic v1, logic [7:0] l1);
`ifdef BYTE_STRIPING_TX_PARITY_EN
        return {v0, l0, ^l0, v1, l1, ^l1};
`else
        return {v0, l0, 1'b0, v1, l1, 1'b0};
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(logic v, logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk_2f);
        #1;
        valid_in = 1'b0;
        data_in  = 8'h00;
    endtask

    // Monitor: every cycle showing a valid flag must match the next queued event.
    always @(negedge clk_2f) begin
        if (valid_0 || valid_1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got v0=%b l0=%h v1=%b l1=%h expected none", valid_0, lane_0, valid_1, lane_1);
            end else begin
                chk("lane_event", 32'({valid_0, lane_0, p0, valid_1, lane_1, p1}), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("reset_async_outputs", 32'({lane_0, lane_1, valid_0, valid_1, holding}), 32'd0);
        @(posedge clk_2f);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00);
            chk("idle_outputs", 32'({lane_0, lane_1, valid_0, valid_1, holding}), 32'd0);
        end
        // Basic pair
        step(1'b1, 8'hA1);
        chk("pair_holding", 32'(holding), 32'd1);
        sb.push_back(ev(1'b1, 8'hA1, 1'b1, 8'hB2));
        step(1'b1, 8'hB2);
        chk("pair_holding_clear", 32'(holding), 32'd0);
        step(1'b0, 8'h00);
        // Continuous stream 00..07
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) sb.push_back(ev(1'b1, 8'(i - 1), 1'b1, 8'(i)));
            step(1'b1, 8'(i));
            chk("stream_holding", 32'(holding), 32'(i % 2 == 0));
        end
        step(1'b0, 8'h00);
        // Odd tail with flush after two idle cycles
        step(1'b1, 8'h11);
        sb.push_back(ev(1'b1, 8'h11, 1'b1, 8'h22));
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        sb.push_back(ev(1'b1, 8'h33, 1'b0, 8'h00));
        step(1'b0, 8'h00);
        chk("tail_still_holding", 32'(holding), 32'd1);
        step(1'b0, 8'h00);
        chk("tail_flushed", 32'(holding), 32'd0);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        // Gap shorter than the flush time inside a pair
        step(1'b1, 8'h5A);
        step(1'b0, 8'h00);
        chk("gap_holding", 32'(holding), 32'd1);
        sb.push_back(ev(1'b1, 8'h5A, 1'b1, 8'hC3));
        step(1'b1, 8'hC3);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        // Reset mid-pair discards the held byte
        step(1'b1, 8'h77);
        chk("midpair_holding", 32'(holding), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midpair_reset_async", 32'({holding, valid_0, valid_1}), 32'd0);
        @(posedge clk_2f);
        #1 reset = 1'b0;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b1, 8'h88);
        sb.push_back(ev(1'b1, 8'h88, 1'b1, 8'h99));
        step(1'b1, 8'h99);
        for (int i = 0; i < 10 && sb.size() != 0; i++) step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
